fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the program memory: owns the PC register, drives the fetch address, and captures the returned instruction into the IF/ID pipeline register.
- Handles sequential PC+4 advance, branch/jump redirect with flush, and hazard stall.
- Program memory is combinational: the instruction for pc_o is valid in the same cycle and is registered at the next rising edge.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset; sampled on rising clk.
- stall_i  input  1  hazard unit hold request; freezes PC and IF/ID.
- redirect_i  input  1  branch taken / jump resolved; load redirect_target_i into the PC.
- redirect_target_i  input  DATA_WIDTH  byte address of the next instruction on redirect.
- instruction_i  input  DATA_WIDTH  instruction returned by program memory for pc_o, same cycle.
- pc_o  output  DATA_WIDTH  fetch address to program memory (current PC register).
- if_id_instruction_o  output  DATA_WIDTH  registered instruction to decode.
- if_id_pc_plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction (link/branch base).
- if_id_valid_o  output  1  1 = IF/ID holds a real instruction; 0 = bubble.

Behaviour:
- All state updates occur on the rising clk edge. No combinational path from any input to any output.
- Reset (reset==0): pc_o=RESET_PC, if_id_instruction_o=NOP_INSTR, if_id_pc_plus4_o=0, if_id_valid_o=0.
- Priority, highest first: reset > redirect_i > stall_i > advance.
- Redirect (redirect_i=1, regardless of stall_i):
  - pc_o <= redirect_target_i.
  - IF/ID flushed: instruction <= NOP_INSTR, valid <= 0, pc_plus4 <= 0.
  - The wrong-path instruction fetched this cycle is discarded.
- Stall (stall_i=1, redirect_i=0): pc_o and all IF/ID outputs hold their values exactly.
- Advance (both 0):
  - pc_o <= pc_o + 4.
  - if_id_instruction_o <= instruction_i.
  - if_id_pc_plus4_o <= pc_o + 4.
  - if_id_valid_o <= 1.
- Latency: the instruction at address A appears on if_id_instruction_o one cycle after pc_o==A, in a cycle with no stall and no redirect.
- First cycle after reset release: pc_o=RESET_PC, valid still 0. The first instruction becomes valid one clock later.
- Arithmetic: PC+4 is computed modulo 2^DATA_WIDTH. 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- Reset asserted during stall or redirect: reset wins; all pending requests are ignored.
- Back-to-back redirects: each is honoured in its cycle; valid stays 0 until the first advance cycle.
- Redirect target is used as given; low two bits are passed through unchanged (see optional feature).

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned_o (1 bit, reset 0).
  - On a redirect with redirect_target_i[1:0]!=0, pc_o <= {redirect_target_i[DATA_WIDTH-1:2],2'b00}.
  - misaligned_o is set to 1 and stays sticky until reset.
- Not defined: no misaligned_o port; target loaded unmodified.

Test Plan:
- Reset held 2 cycles, then released, no stall/redirect, memory returns 32'h2008_0005 at addr 0 and 32'h2009_0003 at addr 4 -> cycle 1 pc_o=0 valid=0; cycle 2 pc_o=4, IF/ID=32'h2008_0005, pc_plus4=4, valid=1; cycle 3 IF/ID=32'h2009_0003, pc_plus4=8.
- From pc_o=8, stall_i=1 for 3 cycles -> pc_o stays 8, IF/ID outputs unchanged all 3 cycles; after release pc_o=12 next edge.
- At pc_o=16, redirect_i=1, target=32'h0000_0040 -> next cycle pc_o=0x40, IF/ID=NOP, valid=0; following cycle valid=1 with the instruction from 0x40, pc_plus4=0x44.
- stall_i=1 and redirect_i=1 together, target=0x20 -> pc_o=0x20, IF/ID flushed (redirect wins).
- Force PC to 32'hFFFF_FFFC via redirect, then advance -> pc_o=0, if_id_pc_plus4_o=0.
- With FETCH_ALIGN_CHECK_EN: redirect target 0x42 -> pc_o=0x40, misaligned_o=1 and stays 1 through later advances until reset=0.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage sitting directly in front of a combinational
//   program memory. Owns the PC, drives the fetch address and captures the
//   returned instruction, together with its PC+4, into the IF/ID register.
//
//   Update priority on each rising clk edge, highest first:
//       reset  >  redirect  >  stall  >  advance
//
//   Optional feature, controlled by macro FETCH_ALIGN_CHECK_EN:
//       defined     - redirect targets are forced to word alignment and
//                     misaligned_o is set sticky (until reset) whenever a
//                     redirect target has non-zero low bits.
//       not defined - target loaded unmodified, no misaligned_o port.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous active-low reset
//   stall_i              hazard hold: PC and IF/ID keep their values
//   redirect_i           branch/jump resolved: load target, flush IF/ID
//   redirect_target_i    byte address of the next instruction on redirect
//   instruction_i        program memory data for pc_o (same cycle)
//   pc_o                 fetch address (PC register)
//   if_id_instruction_o  registered instruction to decode
//   if_id_pc_plus4_o     registered PC+4 of that instruction
//   if_id_valid_o        1 = real instruction, 0 = bubble
//   misaligned_o         sticky misaligned-redirect flag (macro only)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                  misaligned_o,
`endif
    output logic                  if_id_valid_o
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_if_id_instr;
    logic [DATA_WIDTH-1:0] r_if_id_pc_plus4;
    logic                  r_if_id_valid;

    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_redirect_pc;

    // Wraps modulo 2^DATA_WIDTH; no overflow indication is wanted.
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misaligned;
    logic w_target_misaligned;

    assign w_target_misaligned = |redirect_target_i[1:0];
    assign w_redirect_pc       = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_misaligned <= 1'b0;
        end else if (redirect_i && w_target_misaligned) begin
            r_misaligned <= 1'b1;
        end
    end

    assign misaligned_o = r_misaligned;
`else
    assign w_redirect_pc = redirect_target_i;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc             <= RESET_PC;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc_plus4 <= '0;
            r_if_id_valid    <= 1'b0;
        end else if (redirect_i) begin
            // The instruction fetched this cycle is on the wrong path: drop it.
            r_pc             <= w_redirect_pc;
            r_if_id_instr    <= NOP_INSTR;
            r_if_id_pc_plus4 <= '0;
            r_if_id_valid    <= 1'b0;
        end else if (!stall_i) begin
            r_pc             <= w_pc_plus4;
            r_if_id_instr    <= instruction_i;
            r_if_id_pc_plus4 <= w_pc_plus4;
            r_if_id_valid    <= 1'b1;
        end
    end

    assign pc_o                = r_pc;
    assign if_id_instruction_o = r_if_id_instr;
    assign if_id_pc_plus4_o    = r_if_id_pc_plus4;
    assign if_id_valid_o       = r_if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Table-driven bench for fetch_stage. Each vector gives the inputs for one
//   clock edge and the hand-derived register state expected after it. The
//   expectation is pushed to a scoreboard queue when the inputs are driven
//   and popped/compared shortly after the edge. A small program-memory model
//   answers pc_o combinationally. Build with +define+FETCH_ALIGN_CHECK_EN to
//   cover the alignment option.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam int DW = 32;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [DW-1:0] MIS_PC = 32'h0000_0040;
`else
    localparam logic [DW-1:0] MIS_PC = 32'h0000_0042;
`endif
    localparam logic [DW-1:0] NOP = 32'h0000_0000;

    logic          clk;
    logic          reset;
    logic          stall_i;
    logic          redirect_i;
    logic [DW-1:0] redirect_target_i;
    logic [DW-1:0] instruction_i;
    logic [DW-1:0] pc_o;
    logic [DW-1:0] if_id_instruction_o;
    logic [DW-1:0] if_id_pc_plus4_o;
    logic          if_id_valid_o;
`ifdef FETCH_ALIGN_CHECK_EN
    logic          misaligned_o;
`endif

    fetch_stage #(
        .DATA_WIDTH (DW),
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (32'h0000_0000)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall_i             (stall_i),
        .redirect_i          (redirect_i),
        .redirect_target_i   (redirect_target_i),
        .instruction_i       (instruction_i),
        .pc_o                (pc_o),
        .if_id_instruction_o (if_id_instruction_o),
        .if_id_pc_plus4_o    (if_id_pc_plus4_o),
`ifdef FETCH_ALIGN_CHECK_EN
        .misaligned_o        (misaligned_o),
`endif
        .if_id_valid_o       (if_id_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory model.
    function automatic logic [DW-1:0] mem(input logic [DW-1:0] addr);
        case (addr)
            32'h0000_0000: mem = 32'h2008_0005;
            32'h0000_0004: mem = 32'h2009_0003;
            default:       mem = {16'hC0DE, addr[15:0]};
        endcase
    endfunction

    assign instruction_i = mem(pc_o);

    typedef struct {
        logic          rst_n;
        logic          stall;
        logic          redir;
        logic [DW-1:0] target;
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc4;
        logic          valid;
        logic          mis;
    } vec_t;

    typedef struct {
        int            id;
        logic [DW-1:0] pc;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc4;
        logic          valid;
        logic          mis;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input int id,
                         input logic [DW-1:0] got, input logic [DW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, id, got, want);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: queue empty, got 1 expected 0 empty pops");
            return;
        end
        e = sb_q.pop_front();
        check("pc_o",                e.id, pc_o,                e.pc);
        check("if_id_instruction_o", e.id, if_id_instruction_o, e.instr);
        check("if_id_pc_plus4_o",    e.id, if_id_pc_plus4_o,    e.pc4);
        check("if_id_valid_o",       e.id, {31'b0, if_id_valid_o}, {31'b0, e.valid});
`ifdef FETCH_ALIGN_CHECK_EN
        check("misaligned_o",        e.id, {31'b0, misaligned_o},  {31'b0, e.mis});
`endif
    endtask

    // Drive one vector at the falling edge, expect its result after the rise.
    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        reset             = v.rst_n;
        stall_i           = v.stall;
        redirect_i        = v.redir;
        redirect_target_i = v.target;
        e.id = id; e.pc = v.pc; e.instr = v.instr; e.pc4 = v.pc4;
        e.valid = v.valid; e.mis = v.mis;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    initial begin
        reset             = 1'b0;
        stall_i           = 1'b0;
        redirect_i        = 1'b0;
        redirect_target_i = '0;

        //              rst  stl  red  target        pc            instr               pc4           v    mis
        vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,      32'h4,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h8,        32'h2009_0003,      32'h8,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,32'h0,        32'h8,        32'h2009_0003,      32'h8,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,32'h0,        32'h8,        32'h2009_0003,      32'h8,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,32'h0,        32'h8,        32'h2009_0003,      32'h8,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'hC,        32'hC0DE_0008,      32'hC,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h10,       32'hC0DE_000C,      32'h10,       1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,32'h40,       32'h40,       NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h44,       32'hC0DE_0040,      32'h44,       1'b1,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b1,32'h20,       32'h20,       NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,32'h80,       32'h80,       NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,32'h0,        32'h80,       NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h84,       32'hC0DE_0080,      32'h84,       1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h0,        32'hC0DE_FFFC,      32'h0,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,      32'h4,        1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,32'h100,      32'h0,        NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,      32'h4,        1'b1,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b1,32'h42,       MIS_PC,       NOP,                32'h0,        1'b0,1'b1});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        MIS_PC+32'd4, mem(MIS_PC),        MIS_PC+32'd4, 1'b1,1'b1});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        MIS_PC+32'd8, mem(MIS_PC+32'd4),  MIS_PC+32'd8, 1'b1,1'b1});
        vecs.push_back('{1'b0,1'b0,1'b0,32'h0,        32'h0,        NOP,                32'h0,        1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,32'h0,        32'h4,        32'h2008_0005,      32'h4,        1'b1,1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        // Hand sequence: inputs must not reach outputs before the edge.
        @(negedge clk);
        redirect_i        = 1'b1;
        stall_i           = 1'b1;
        redirect_target_i = 32'h0000_0100;
        #1;
        check("comb_path_pc",    100, pc_o, 32'h4);
        check("comb_path_valid", 100, {31'b0, if_id_valid_o}, 32'h1);
        sb_q.push_back('{100, 32'h100, NOP, 32'h0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        compare_pop();

        // Hand sequence: long stall after a redirect keeps the bubble, then
        // the first advance delivers the instruction at the target.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            redirect_i = 1'b0;
            stall_i    = 1'b1;
            sb_q.push_back('{101 + k, 32'h100, NOP, 32'h0, 1'b0, 1'b0});
            @(posedge clk);
            #1;
            compare_pop();
        end
        @(negedge clk);
        stall_i = 1'b0;
        sb_q.push_back('{105, 32'h104, 32'hC0DE_0100, 32'h104, 1'b1, 1'b0});
        @(posedge clk);
        #1;
        compare_pop();

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
